// File: rtl/traffic_lane_engine.sv
// traffic_lane_engine
// Moves the cars of a lane-based road playfield and answers tile queries.
// A frame tick starts an update sequence that visits one lane per cycle.
// Each lane owns a step counter; the lane's cars advance one tile when the
// counter expires, and the counter then reloads with a level-dependent period.
//
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Frame_Tick        one-cycle pulse per video frame
//   i_Level             current game level (speeds traffic up)
//   i_Frog_X, i_Frog_Y  frog tile, checked against car positions
//   i_Col_Div, i_Row_Div pixel tile, checked against car positions
//   o_Car_Hit           registered: queried pixel tile holds a car
//   o_Collided          registered: frog tile holds a car
//   o_Busy              update sequence in progress
//   o_Update_Done       one-cycle pulse at the end of a sequence
//   o_Tick_Overrun      sticky: a tick arrived while busy and was dropped
//
// Optional feature (macro TRAFFIC_PAUSE_EN): adds input i_Pause. While paused,
// ticks seen in IDLE are ignored (no sequence, no overrun); a sequence
// already running still completes.
`timescale 1ns/1ps
module traffic_lane_engine #(
  parameter int NUM_LANES      = 5,
  parameter int CARS_PER_LANE  = 2,
  parameter int GRID_W         = 20,
  parameter int FIRST_LANE_ROW = 12,
  parameter int BASE_PERIOD    = 8,
  parameter int MIN_PERIOD     = 2,
  parameter int LEVEL_STEP     = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
`ifdef TRAFFIC_PAUSE_EN
  input  logic       i_Pause,
`endif
  input  logic       i_Frame_Tick,
  input  logic [6:0] i_Level,
  input  logic [4:0] i_Frog_X,
  input  logic [4:0] i_Frog_Y,
  input  logic [4:0] i_Col_Div,
  input  logic [4:0] i_Row_Div,
  output logic       o_Car_Hit,
  output logic       o_Collided,
  output logic       o_Busy,
  output logic       o_Update_Done,
  output logic       o_Tick_Overrun
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [4:0]          car_x_q [NUM_LANES][CARS_PER_LANE];
  logic [4:0]          car_x_d [NUM_LANES][CARS_PER_LANE];
  logic [15:0]         cnt_q [NUM_LANES];
  logic [15:0]         cnt_d [NUM_LANES];
  logic                car_hit_q, car_hit_d;
  logic                collided_q, collided_d;
  logic                overrun_q, overrun_d;
  logic                pause;
  logic                tick_ok;

`ifdef TRAFFIC_PAUSE_EN
  assign pause = i_Pause;
`else
  assign pause = 1'b0;
`endif

  assign tick_ok = i_Frame_Tick & ~pause;

  // Period = max(MIN_PERIOD, BASE_PERIOD + lane - level*LEVEL_STEP); the
  // subtraction saturates at zero so high levels cannot wrap the counter.
  function automatic logic [15:0] reload_val(input int lane, input logic [6:0] level);
    logic [15:0] base;
    logic [15:0] dec;
    logic [15:0] diff;
    base = 16'(BASE_PERIOD + lane);
    dec  = 16'(level) * 16'(LEVEL_STEP);
    diff = (base > dec) ? (base - dec) : 16'd0;
    return (diff < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : diff;
  endfunction

  function automatic logic [4:0] init_x(input int lane, input int car);
    return 5'((car * (GRID_W / CARS_PER_LANE) + 3 * lane) % GRID_W);
  endfunction

  // Even lanes drive right, odd lanes drive left, both wrap at the edges.
  function automatic logic [4:0] step_x(input logic [4:0] x, input logic right);
    if (right) return (x == 5'(GRID_W - 1)) ? 5'd0 : (x + 5'd1);
    else       return (x == 5'd0) ? 5'(GRID_W - 1) : (x - 5'd1);
  endfunction

  // Sequencer and lane update
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    car_x_d   = car_x_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (tick_ok) begin
          state_d = ST_UPDATE;
          lane_d  = '0;
        end
      end
      ST_UPDATE: begin
        if (lane_q == LANE_W'(NUM_LANES - 1)) state_d = ST_DONE;
        else                                  lane_d  = lane_q + 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int l = 0; l < NUM_LANES; l++) begin
      if (state_q == ST_UPDATE && lane_q == LANE_W'(l)) begin
        if (cnt_q[l] > 16'd1) begin
          cnt_d[l] = cnt_q[l] - 16'd1;
        end else begin
          cnt_d[l] = reload_val(l, i_Level);
          for (int k = 0; k < CARS_PER_LANE; k++)
            car_x_d[l][k] = step_x(car_x_q[l][k], (l % 2) == 0);
        end
      end
    end

    if (state_q != ST_IDLE && tick_ok) overrun_d = 1'b1;
  end

  // Tile queries against the current positions
  always_comb begin
    car_hit_d  = 1'b0;
    collided_d = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < CARS_PER_LANE; k++) begin
        if (int'(i_Row_Div) == FIRST_LANE_ROW - l && car_x_q[l][k] == i_Col_Div)
          car_hit_d = 1'b1;
        if (int'(i_Frog_Y) == FIRST_LANE_ROW - l && car_x_q[l][k] == i_Frog_X)
          collided_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      car_hit_q  <= 1'b0;
      collided_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        cnt_q[l] <= reload_val(l, 7'd0);
        for (int k = 0; k < CARS_PER_LANE; k++)
          car_x_q[l][k] <= init_x(l, k);
      end
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      car_hit_q  <= car_hit_d;
      collided_q <= collided_d;
      overrun_q  <= overrun_d;
      cnt_q      <= cnt_d;
      car_x_q    <= car_x_d;
    end
  end

  assign o_Car_Hit      = car_hit_q;
  assign o_Collided     = collided_q;
  assign o_Busy         = (state_q != ST_IDLE);
  assign o_Update_Done  = (state_q == ST_DONE);
  assign o_Tick_Overrun = overrun_q;

endmodule
